// File: rtl/fir_run_sequencer.sv
// fir_run_sequencer
// Run-level controller for an n-tap FIR datapath. Each run loads LENGTH
// coefficients from a synchronous-read coefficient memory into the FIR,
// streams sampleCount samples from a valid/ready source, flushes the FIR
// with LENGTH zeros, forwards the full convolution as a valid-qualified
// stream, then stops the FIR and pulses done.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, sampleCount    run request (IDLE only) and sample count N (latched)
//   coeffAddr, coeffData  coefficient memory address / data (1-cycle latency)
//   sampleIn, sampleValid, sampleReady   sample source handshake
//   firLoadCoeff, firCoeffIn, firLoadDataFlag, firStopDataLoadFlag,
//   firDataIn, firDataOut                FIR datapath control and data
//   resultOut, resultValid               convolution result stream
//   busy, done                           run status
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_RST    | first cycle after reset, every output held at 0
// S_RESYNC | 3 cycles of FIR stop flag to return the FIR to idle
// S_IDLE   | waiting for start with a non-zero sample count
// S_COEFF  | LENGTH+2 cycles: address coefficients, feed FIR, guard cycle
// S_STREAM | accept N samples from the source, one FIR load per accept
// S_FLUSH  | LENGTH zero loads to push out the convolution tail
// S_DRAIN  | one cycle to capture the final FIR output
// S_STOP   | 2 cycles of FIR stop flag
// S_WAIT   | done pulse, back to IDLE
module fir_run_sequencer #(
  parameter int LENGTH           = 20,
  parameter int DATA_WIDTH       = 8,
  parameter int COEFF_ADDR_WIDTH = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [15:0]                    sampleCount,
  output logic [COEFF_ADDR_WIDTH-1:0]    coeffAddr,
  input  logic signed [DATA_WIDTH-1:0]   coeffData,
  input  logic signed [DATA_WIDTH-1:0]   sampleIn,
  input  logic                           sampleValid,
  output logic                           sampleReady,
  output logic                           firLoadCoeff,
  output logic signed [DATA_WIDTH-1:0]   firCoeffIn,
  output logic                           firLoadDataFlag,
  output logic                           firStopDataLoadFlag,
  output logic signed [DATA_WIDTH-1:0]   firDataIn,
  input  logic signed [3*DATA_WIDTH-1:0] firDataOut,
  output logic signed [3*DATA_WIDTH-1:0] resultOut,
  output logic                           resultValid,
  output logic                           busy,
  output logic                           done
);

  // The tap counter must reach LENGTH+1 for the coefficient phase.
  localparam int TAP_W = $clog2(LENGTH + 2);
  typedef logic [TAP_W-1:0] tap_t;

  localparam tap_t TAP_COEFF  = tap_t'(LENGTH + 1);
  localparam tap_t TAP_FLUSH  = tap_t'(LENGTH - 1);
  localparam tap_t TAP_LAST   = tap_t'(LENGTH - 1);
  localparam tap_t TAP_RESYNC = tap_t'(2);
  localparam tap_t TAP_STOP   = tap_t'(1);

  typedef enum logic [3:0] {
    S_RST,
    S_RESYNC,
    S_IDLE,
    S_COEFF,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_STOP,
    S_WAIT
  } state_t;

  state_t      state, state_nxt;
  tap_t        tap_cnt, tap_nxt;
  logic [15:0] sample_cnt, sample_nxt;
  logic        seen_load, seen_load_nxt;
  logic        result_valid, result_valid_nxt;
  logic        load;
  tap_t        coeff_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_RST;
      tap_cnt      <= '0;
      sample_cnt   <= '0;
      seen_load    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      tap_cnt      <= tap_nxt;
      sample_cnt   <= sample_nxt;
      seen_load    <= seen_load_nxt;
      result_valid <= result_valid_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    tap_nxt             = tap_cnt;
    sample_nxt          = sample_cnt;
    load                = 1'b0;
    coeff_idx           = '0;
    sampleReady         = 1'b0;
    firLoadCoeff        = 1'b0;
    firCoeffIn          = '0;
    firStopDataLoadFlag = 1'b0;
    firDataIn           = '0;
    busy                = 1'b0;
    done                = 1'b0;

    case (state)
      S_RST: begin
        state_nxt = S_RESYNC;
        tap_nxt   = TAP_RESYNC;
      end

      S_RESYNC: begin
        busy                = 1'b1;
        firStopDataLoadFlag = 1'b1;
        if (tap_cnt == '0) state_nxt = S_IDLE;
        else               tap_nxt   = tap_cnt - tap_t'(1);
      end

      S_IDLE: begin
        if (start && (sampleCount != 16'd0)) begin
          state_nxt  = S_COEFF;
          sample_nxt = sampleCount;
          tap_nxt    = TAP_COEFF;
        end
      end

      S_COEFF: begin
        busy         = 1'b1;
        firLoadCoeff = (tap_cnt == TAP_COEFF);
        // Cycle c_k has tap_cnt = LENGTH+1-k. Past the last address the
        // address is parked on LENGTH-1 so the memory keeps presenting the
        // final coefficient through the guard cycle.
        if (tap_cnt >= tap_t'(2)) coeff_idx = TAP_COEFF - tap_cnt;
        else                      coeff_idx = TAP_LAST;
        // The memory's own output register supplies the one-cycle alignment.
        if (tap_cnt != TAP_COEFF) firCoeffIn = coeffData;
        if (tap_cnt == '0) state_nxt = S_STREAM;
        else               tap_nxt   = tap_cnt - tap_t'(1);
      end

      S_STREAM: begin
        busy        = 1'b1;
        sampleReady = 1'b1;
        if (sampleValid) begin
          load       = 1'b1;
          firDataIn  = sampleIn;
          sample_nxt = sample_cnt - 16'd1;
          if (sample_cnt == 16'd1) begin
            state_nxt = S_FLUSH;
            tap_nxt   = TAP_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        busy = 1'b1;
        load = 1'b1;
        if (tap_cnt == '0) state_nxt = S_DRAIN;
        else               tap_nxt   = tap_cnt - tap_t'(1);
      end

      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_STOP;
        tap_nxt   = TAP_STOP;
      end

      S_STOP: begin
        busy                = 1'b1;
        firStopDataLoadFlag = 1'b1;
        if (tap_cnt == '0) state_nxt = S_WAIT;
        else               tap_nxt   = tap_cnt - tap_t'(1);
      end

      S_WAIT: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_RST;
      end
    endcase

    coeffAddr       = COEFF_ADDR_WIDTH'(coeff_idx);
    firLoadDataFlag = load;

    // The FIR output after the first load of a run reflects an empty
    // history, so only loads after the first produce a result.
    result_valid_nxt = load && seen_load;
    seen_load_nxt    = (state == S_IDLE) ? 1'b0 : (seen_load | load);
  end

  assign resultValid = result_valid;
  assign resultOut   = result_valid ? firDataOut : '0;

endmodule

// File: tb/tb_fir_run_sequencer.sv
// Testbench for fir_run_sequencer with LENGTH=4. Contains a synchronous
// coefficient memory, a behavioural FIR that captures the coefficients the
// controller delivers, and a reference convolution computed directly from
// memory contents and the sample list.
module tb_fir_run_sequencer;

  localparam int L  = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int RW = 3 * DW;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [15:0]          sampleCount = 16'd0;
  logic [AW-1:0]        coeffAddr;
  logic signed [DW-1:0] coeffData = '0;
  logic signed [DW-1:0] sampleIn = '0;
  logic                 sampleValid = 1'b0;
  logic                 sampleReady;
  logic                 firLoadCoeff;
  logic signed [DW-1:0] firCoeffIn;
  logic                 firLoadDataFlag;
  logic                 firStopDataLoadFlag;
  logic signed [DW-1:0] firDataIn;
  logic signed [RW-1:0] firDataOut = '0;
  logic signed [RW-1:0] resultOut;
  logic                 resultValid;
  logic                 busy;
  logic                 done;

  always #5 clock = ~clock;

  fir_run_sequencer #(
    .LENGTH(L), .DATA_WIDTH(DW), .COEFF_ADDR_WIDTH(AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .sampleCount(sampleCount),
    .coeffAddr(coeffAddr), .coeffData(coeffData), .sampleIn(sampleIn),
    .sampleValid(sampleValid), .sampleReady(sampleReady),
    .firLoadCoeff(firLoadCoeff), .firCoeffIn(firCoeffIn),
    .firLoadDataFlag(firLoadDataFlag), .firStopDataLoadFlag(firStopDataLoadFlag),
    .firDataIn(firDataIn), .firDataOut(firDataOut), .resultOut(resultOut),
    .resultValid(resultValid), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic signed [DW-1:0] mem [L];
  logic signed [DW-1:0] xs [32];
  logic signed [RW-1:0] exp_q [$];

  // Coefficient memory: address sampled on the edge, data valid next cycle.
  always @(posedge clock) coeffData <= mem[coeffAddr];

  // Behavioural FIR: captures L coefficients in the cycles after loadCoeff;
  // each data load outputs the sum over the history before the new sample.
  logic signed [DW-1:0] fir_h [L];
  logic signed [DW-1:0] fir_hist [L];
  int cap_idx = L;
  always @(posedge clock) begin
    int acc;
    if (firLoadCoeff) cap_idx <= 0;
    else if (cap_idx < L) begin
      fir_h[cap_idx] <= firCoeffIn;
      cap_idx <= cap_idx + 1;
    end
    if (firStopDataLoadFlag) begin
      for (int j = 0; j < L; j++) fir_hist[j] <= '0;
      firDataOut <= '0;
    end else if (firLoadDataFlag) begin
      acc = 0;
      for (int j = 0; j < L; j++) acc += int'(fir_h[j]) * int'(fir_hist[j]);
      firDataOut <= RW'(acc);
      fir_hist[0] <= firDataIn;
      for (int j = 1; j < L; j++) fir_hist[j] <= fir_hist[j-1];
    end
  end

  // Monitor
  logic signed [RW-1:0] got [$];
  int done_cnt = 0;
  int lc_cnt = 0;
  int bad_load = 0;
  always @(negedge clock) begin
    if (resultValid) got.push_back(resultOut);
    if (done) done_cnt++;
    if (firLoadCoeff) lc_cnt++;
    if (sampleReady && firLoadDataFlag && (!sampleValid || firDataIn !== sampleIn))
      bad_load++;
  end

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n + L - 1; i++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < L; k++)
        if (i - k >= 0 && i - k < n) acc += int'(mem[k]) * int'(xs[i-k]);
      exp_q.push_back(RW'(acc));
    end
  endtask

  // One complete run. stall_mode: 0 valid held high, 1 valid low on
  // alternate cycles, 2 random valid. poke pulses start throughout the run.
  task automatic run_check(input string name, input int n, input int stall_mode,
                           input bit poke);
    int cyc, stalls, first_rdy, idx, got_base, done_base, lc_base, bad_base, ci, nres;
    bit seen_done;
    logic signed [DW-1:0] ecoef;
    build_exp(n);
    got_base = got.size(); done_base = done_cnt; lc_base = lc_cnt; bad_base = bad_load;
    cyc = 1; stalls = 0; first_rdy = 0; idx = 0; seen_done = 0;
    @(posedge clock); #1;
    start = 1'b1; sampleCount = 16'(n); sampleValid = 1'b0;
    while (!seen_done && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
      start = poke && (cyc % 2 == 1);
      sampleCount = 16'($urandom_range(1, 9));
      case (stall_mode)
        0:       sampleValid = 1'b1;
        1:       sampleValid = (cyc % 2 == 1);
        default: sampleValid = 1'($urandom_range(0, 1));
      endcase
      sampleIn = (idx < n) ? xs[idx] : DW'($urandom);
      @(negedge clock);
      if (sampleReady && first_rdy == 0) first_rdy = cyc;
      if (sampleReady && !sampleValid) stalls++;
      if (sampleReady && sampleValid) idx++;
      if (cyc >= 2 && cyc <= L + 3) begin
        ci = cyc - 2;
        vectors++;
        if (firLoadCoeff !== (ci == 0)) begin
          miscompares++;
          $display("FAIL %s loadCoeff c%0d: got %b want %b", name, ci, firLoadCoeff, ci == 0);
        end
        if (ci < L) begin
          vectors++;
          if (coeffAddr !== AW'(ci)) begin
            miscompares++;
            $display("FAIL %s coeffAddr c%0d: got %0d want %0d", name, ci, coeffAddr, ci);
          end
        end
        if (ci >= 1) begin
          ecoef = (ci <= L) ? mem[ci-1] : mem[L-1];
          vectors++;
          if (firCoeffIn !== ecoef) begin
            miscompares++;
            $display("FAIL %s coeffIn c%0d: got %0d want %0d", name, ci, firCoeffIn, ecoef);
          end
        end
        vectors++;
        if (firLoadDataFlag !== 1'b0) begin
          miscompares++;
          $display("FAIL %s early data load c%0d: got %b want 0", name, ci, firLoadDataFlag);
        end
      end
      if (done) seen_done = 1'b1;
    end
    @(posedge clock); #1;
    start = 1'b0; sampleValid = 1'b0;

    vectors++;
    if (!seen_done) begin
      miscompares++;
      $display("FAIL %s timeout: got no done within %0d cycles want done", name, cyc);
    end
    vectors++;
    if (cyc != 2 * L + n + 7 + stalls) begin
      miscompares++;
      $display("FAIL %s run length: got %0d want %0d", name, cyc, 2 * L + n + 7 + stalls);
    end
    vectors++;
    if (first_rdy != L + 4) begin
      miscompares++;
      $display("FAIL %s first ready cycle: got %0d want %0d", name, first_rdy, L + 4);
    end
    nres = got.size() - got_base;
    vectors++;
    if (nres != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s result count: got %0d want %0d", name, nres, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < nres; i++) begin
      vectors++;
      if (got[got_base + i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s result[%0d]: got %0d want %0d", name, i, got[got_base + i], exp_q[i]);
      end
    end
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (busy !== 1'b0 || firLoadCoeff !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle after done: got busy=%b loadCoeff=%b want 0 0", name, busy, firLoadCoeff);
      end
    end
    vectors++;
    if (done_cnt - done_base != 1 || lc_cnt - lc_base != 1) begin
      miscompares++;
      $display("FAIL %s pulses: got done=%0d loadCoeff=%0d want 1 1", name,
               done_cnt - done_base, lc_cnt - lc_base);
    end
    vectors++;
    if (bad_load != bad_base) begin
      miscompares++;
      $display("FAIL %s stream loads: got %0d bad loads want 0", name, bad_load - bad_base);
    end
  endtask

  // Applies reset for one cycle (optionally together with start) and checks
  // the zeroed cycle, the 3-cycle resync and arrival in idle.
  task automatic reset_and_check(input string name, input bit with_start);
    int got_base, done_base, lc_base;
    @(posedge clock); #1;
    reset = 1'b1; start = with_start; sampleCount = 16'd3;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0; sampleValid = 1'b0;
    got_base = got.size(); done_base = done_cnt; lc_base = lc_cnt;
    @(negedge clock);
    vectors++;
    if ({coeffAddr, sampleReady, firLoadCoeff, firCoeffIn, firLoadDataFlag,
         firStopDataLoadFlag, firDataIn, resultOut, resultValid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs after reset: got addr=%0d rdy=%b lc=%b stop=%b ld=%b rv=%b busy=%b done=%b want all 0",
               name, coeffAddr, sampleReady, firLoadCoeff, firStopDataLoadFlag,
               firLoadDataFlag, resultValid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (firStopDataLoadFlag !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s resync %0d: got stop=%b busy=%b want 1 1", name, i, firStopDataLoadFlag, busy);
      end
    end
    @(negedge clock);
    vectors++;
    if (firStopDataLoadFlag !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle after resync: got stop=%b busy=%b want 0 0", name, firStopDataLoadFlag, busy);
    end
    vectors++;
    if (got.size() != got_base || done_cnt != done_base || lc_cnt != lc_base) begin
      miscompares++;
      $display("FAIL %s activity after reset: got results=%0d done=%0d loadCoeff=%0d want 0 0 0", name,
               got.size() - got_base, done_cnt - done_base, lc_cnt - lc_base);
    end
  endtask

  task automatic set_plan_coeffs();
    mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
  endtask

  task automatic test_reset();
    reset_and_check("reset", 1'b0);
  endtask

  task automatic test_impulse();
    set_plan_coeffs();
    xs[0] = 8'sd1; xs[1] = 8'sd0; xs[2] = 8'sd0;
    run_check("impulse", 3, 0, 1'b0);
  endtask

  task automatic test_mixed();
    set_plan_coeffs();
    xs[0] = 8'sd2; xs[1] = -8'sd1; xs[2] = 8'sd3;
    run_check("mixed", 3, 0, 1'b0);
  endtask

  task automatic test_stall();
    set_plan_coeffs();
    xs[0] = 8'sd2; xs[1] = -8'sd1; xs[2] = 8'sd3;
    run_check("stall", 3, 1, 1'b0);
  endtask

  task automatic test_ignore();
    int done_base, lc_base;
    done_base = done_cnt; lc_base = lc_cnt;
    @(posedge clock); #1;
    start = 1'b1; sampleCount = 16'd0;
    @(posedge clock); #1;
    start = 1'b0; sampleCount = 16'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_count busy cycle %0d: got %b want 0", i, busy);
      end
    end
    vectors++;
    if (lc_cnt != lc_base || done_cnt != done_base) begin
      miscompares++;
      $display("FAIL zero_count pulses: got loadCoeff=%0d done=%0d want 0 0",
               lc_cnt - lc_base, done_cnt - done_base);
    end
    set_plan_coeffs();
    for (int i = 0; i < 5; i++) xs[i] = DW'($urandom);
    run_check("busy_start", 5, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    set_plan_coeffs();
    @(posedge clock); #1;
    start = 1'b1; sampleCount = 16'd5; sampleValid = 1'b1; sampleIn = 8'sd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (L + 4) @(posedge clock);
    #1;
    reset_and_check("mid_run_reset", 1'b0);
    xs[0] = 8'sd1; xs[1] = 8'sd0; xs[2] = 8'sd0;
    run_check("impulse_after_reset", 3, 0, 1'b0);
  endtask

  task automatic test_start_with_reset();
    reset_and_check("start_with_reset", 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < L; k++) mem[k] = DW'($urandom);
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) xs[i] = DW'($urandom);
      run_check("random", n, 2, r[0]);
    end
  endtask

  initial begin
    set_plan_coeffs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    test_reset();
    test_impulse();
    test_mixed();
    test_stall();
    test_ignore();
    test_reset_mid_run();
    test_start_with_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
